// File: rtl/responder_pkg.sv
// Shared types and constants for the five-contestant quiz responder.
package responder_pkg;

  localparam int         N_PLAYERS = 5;
  localparam logic [2:0] NO_WINNER = 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED,
    TIMEOUT
  } state_t;

  // Keep only the highest-priority request; bit N_PLAYERS-1 is player 1.
  function automatic logic [N_PLAYERS-1:0] pick_winner(input logic [N_PLAYERS-1:0] req);
    logic [N_PLAYERS-1:0] pick;
    pick = '0;
    for (int k = N_PLAYERS - 1; k >= 0; k--) begin
      if (req[k] && (pick == '0)) pick[k] = 1'b1;
    end
    return pick;
  endfunction

  // Player number (1..N_PLAYERS) of a one-hot grant; NO_WINNER when empty.
  function automatic logic [2:0] player_id(input logic [N_PLAYERS-1:0] onehot);
    logic [2:0] id;
    id = NO_WINNER;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (onehot[k]) id = 3'(N_PLAYERS - k);
    end
    return id;
  endfunction

endpackage

// File: rtl/responder_key_sync.sv
// One contestant key: 2-flop synchronizer, debounce filter, rising-edge pulse.
module responder_key_sync #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic p
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          hist_q;
  logic          p_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Filter: flip the accepted level on the Nth consecutive differing sample.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                    cnt_d   = cnt_q + 1'b1;
    end
  end

  // Synchronizer, filter state and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      hist_q  <= 1'b0;
      p_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= key;
      sync2_q <= sync1_q;
      level_q <= level_d;
      hist_q  <= level_q;
      p_q     <= level_q & ~hist_q;
      cnt_q   <= cnt_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/responder_arbiter.sv
// Lock-out arbiter: grants the first eligible press after start, flags early
// presses as fouls and closes the answer window on timeout.
module responder_arbiter
  import responder_pkg::*;
#(
  parameter  int N               = N_PLAYERS,
  parameter  int DEBOUNCE_CYCLES = 20000,
  parameter  int WINDOW_CYCLES   = 500000000,
  localparam int RW              = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  key,
  input  logic          start,
  input  logic          clear,
  output logic [N-1:0]  winner,
  output logic [2:0]    winner_id,
  output logic [N-1:0]  foul,
  output logic          armed,
  output logic          timeout,
  output logic [RW-1:0] remaining
);

  state_t        state_q, state_d;
  logic [N-1:0]  press;
  logic [N-1:0]  grant;
  logic [N-1:0]  winner_q, winner_d;
  logic [2:0]    id_q, id_d;
  logic [N-1:0]  foul_q, foul_d;
  logic          timeout_q, timeout_d;
  logic [RW-1:0] remaining_q, remaining_d;

  for (genvar k = 0; k < N; k++) begin : g_key
    responder_key_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_sync (
      .clk (clk),
      .rst (rst),
      .key (key[k]),
      .p   (press[k])
    );
  end

  // Fouled players can never be granted, even when pressing alongside others.
  assign grant = pick_winner(press & ~foul_q);

  // Next-state, grant capture and window countdown.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    id_d        = id_q;
    foul_d      = foul_q;
    timeout_d   = timeout_q;
    remaining_d = remaining_q;
    if (clear) begin
      state_d     = IDLE;
      winner_d    = '0;
      id_d        = NO_WINNER;
      foul_d      = '0;
      timeout_d   = 1'b0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          foul_d = foul_q | press;
          if (start) begin
            state_d     = ARMED;
            remaining_d = RW'(WINDOW_CYCLES);
          end
        end
        ARMED: begin
          // An eligible press on the last window cycle still wins.
          if (grant != '0) begin
            state_d     = LOCKED;
            winner_d    = grant;
            id_d        = player_id(grant);
            remaining_d = '0;
          end else if (remaining_q == RW'(1)) begin
            state_d     = TIMEOUT;
            timeout_d   = 1'b1;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
        LOCKED, TIMEOUT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      id_q        <= NO_WINNER;
      foul_q      <= '0;
      timeout_q   <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      id_q        <= id_d;
      foul_q      <= foul_d;
      timeout_q   <= timeout_d;
      remaining_q <= remaining_d;
    end
  end

  assign winner    = winner_q;
  assign winner_id = id_q;
  assign foul      = foul_q;
  assign armed     = (state_q == ARMED);
  assign timeout   = timeout_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed bench for responder_arbiter with a scoreboard of expected outputs.
module tb_responder_arbiter;

  localparam int DB  = 4;
  localparam int WIN = 20;
  localparam int RW  = $clog2(WIN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    key;
  logic          start;
  logic          clear;
  logic [4:0]    winner;
  logic [2:0]    winner_id;
  logic [4:0]    foul;
  logic          armed;
  logic          timeout;
  logic [RW-1:0] remaining;

  typedef struct packed {
    logic [4:0]    winner;
    logic [2:0]    id;
    logic [4:0]    foul;
    logic          armed;
    logic          timeout;
    logic [RW-1:0] remaining;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  responder_arbiter #(
    .N               (5),
    .DEBOUNCE_CYCLES (DB),
    .WINDOW_CYCLES   (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .start     (start),
    .clear     (clear),
    .winner    (winner),
    .winner_id (winner_id),
    .foul      (foul),
    .armed     (armed),
    .timeout   (timeout),
    .remaining (remaining)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [4:0] w, input logic [2:0] id, input logic [4:0] f,
                            input logic a, input logic t, input int r);
    exp_t e;
    e.winner    = w;
    e.id        = id;
    e.foul      = f;
    e.armed     = a;
    e.timeout   = t;
    e.remaining = RW'(r);
    sb.push_back(e);
  endtask

  task automatic expect_zero();
    expect_out(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected a queued entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".winner"},    32'(winner),    32'(e.winner));
      check({tag, ".winner_id"}, 32'(winner_id), 32'(e.id));
      check({tag, ".foul"},      32'(foul),      32'(e.foul));
      check({tag, ".armed"},     32'(armed),     32'(e.armed));
      check({tag, ".timeout"},   32'(timeout),   32'(e.timeout));
      check({tag, ".remaining"}, 32'(remaining), 32'(e.remaining));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    key   = '0;
    start = 1'b0;
    clear = 1'b0;
    tick(3);
    expect_zero();
    check_out("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      expect_zero();
      tick();
      check_out("idle_quiet");
    end

    // Single press: grant 8 edges after the key is driven (p after 7).
    pulse_start();
    expect_out(5'b0, 3'd0, 5'b0, 1'b1, 1'b0, WIN);
    check_out("a_armed");
    key = 5'b00100;
    for (int i = 1; i <= 7; i++) expect_out(5'b0, 3'd0, 5'b0, 1'b1, 1'b0, WIN - i);
    expect_out(5'b00100, 3'd3, 5'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("a_wait");
    end
    tick();
    check_out("a_grant");
    key = 5'b10000;
    expect_out(5'b00100, 3'd3, 5'b0, 1'b0, 1'b0, 0);
    tick(12);
    check_out("a_locked_hold");
    key = '0;
    tick(10);
    pulse_clear();
    expect_zero();
    check_out("a_clear");

    // Two simultaneous presses: player 2 outranks player 5.
    pulse_start();
    key = 5'b01001;
    expect_out(5'b01000, 3'd2, 5'b0, 1'b0, 1'b0, 0);
    tick(8);
    check_out("b_priority");
    key = '0;
    tick(10);
    pulse_clear();

    // Press lands on the same IDLE edge as start: foul, yet still ARMED.
    key = 5'b00010;
    expect_zero();
    tick(7);
    check_out("c_pre_foul");
    start = 1'b1;
    expect_out(5'b0, 3'd0, 5'b00010, 1'b1, 1'b0, WIN);
    tick();
    start = 1'b0;
    check_out("c_foul_and_armed");
    key = '0;
    tick(8);
    key = 5'b00011;
    expect_out(5'b00001, 3'd5, 5'b00010, 1'b0, 1'b0, 0);
    tick(8);
    check_out("c_fouled_skipped");
    key = '0;
    tick(10);
    pulse_clear();
    expect_zero();
    check_out("c_clear");

    // No press: full window, then timeout; late press ignored.
    pulse_start();
    for (int r = WIN; r >= 1; r--) expect_out(5'b0, 3'd0, 5'b0, 1'b1, 1'b0, r);
    expect_out(5'b0, 3'd0, 5'b0, 1'b0, 1'b1, 0);
    check_out("d_count");
    for (int r = WIN - 1; r >= 1; r--) begin
      tick();
      check_out("d_count");
    end
    tick();
    check_out("d_timeout");
    key = 5'b10000;
    expect_out(5'b0, 3'd0, 5'b0, 1'b0, 1'b1, 0);
    tick(12);
    check_out("d_late_press");
    key = '0;
    tick(10);
    pulse_clear();
    expect_zero();
    check_out("d_clear");

    // Eligible press on the last window cycle beats timeout.
    pulse_start();
    tick(12);
    expect_out(5'b0, 3'd0, 5'b0, 1'b1, 1'b0, 8);
    check_out("e_window");
    key = 5'b00001;
    expect_out(5'b0, 3'd0, 5'b0, 1'b1, 1'b0, 1);
    expect_out(5'b00001, 3'd5, 5'b0, 1'b0, 1'b0, 0);
    tick(7);
    check_out("e_last_cycle");
    tick();
    check_out("e_grant_wins");
    key = '0;
    tick(10);
    pulse_clear();

    // Short glitch is filtered; reset while LOCKED clears everything.
    pulse_start();
    key = 5'b00100;
    tick(3);
    key = '0;
    tick(9);
    expect_out(5'b0, 3'd0, 5'b0, 1'b1, 1'b0, 8);
    check_out("f_glitch");
    key = 5'b10000;
    expect_out(5'b10000, 3'd1, 5'b0, 1'b0, 1'b0, 0);
    tick(8);
    check_out("f_locked");
    rst = 1'b1;
    #1;
    expect_zero();
    check_out("f_reset_mid");
    key = '0;
    tick(3);
    rst = 1'b0;
    tick(10);
    expect_zero();
    check_out("f_after_reset");

    // Clear and start together: clear wins, stays IDLE.
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    expect_zero();
    check_out("g_clear_beats_start");
    tick(3);
    expect_zero();
    check_out("g_still_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
